// File: rtl/spi_link_arbiter.sv
// Round-robin arbiter sharing one SPI slave engine between the UART bridge (req 0) and multiplier path (req 1).
// Define SPI_ARB_TIMEOUT_EN to enable the BUSY watchdog that ends a stuck transfer with err=1.
module spi_link_arbiter #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] tx_data0,
    input  logic [15:0] tx_data1,
    input  logic [1:0]  freq0,
    input  logic [1:0]  freq1,
    input  logic        loop0,
    input  logic        loop1,
    output logic [1:0]  done,
    output logic        err,
    output logic [15:0] rx_data,
    output logic [1:0]  grant,
    output logic        eng_tx_start,
    output logic        eng_rx_start,
    output logic [1:0]  eng_freq_control,
    output logic        eng_loopback,
    output logic [15:0] eng_tx_data,
    input  logic [15:0] eng_rx_data,
    input  logic        eng_tx_done,
    input  logic        eng_rx_valid,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  settle_q, settle_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  done_q, done_d;
    logic        start_q, start_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        tx_seen_q, tx_seen_d;
    logic        rx_seen_q, rx_seen_d;
    logic [15:0] tx_word_q, tx_word_d;
    logic [1:0]  freq_q, freq_d;
    logic        loop_q, loop_d;
    logic        tx_now, rx_now, pick1;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        done_d       = 2'b00;
        start_d      = 1'b0;
        rx_data_d    = rx_data_q;
        tx_seen_d    = tx_seen_q;
        rx_seen_d    = rx_seen_q;
        tx_word_d    = tx_word_q;
        freq_d       = freq_q;
        loop_d       = loop_q;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
        err_d        = 1'b0;
`endif
        // Completion seen this cycle counts together with anything already latched.
        tx_now = tx_seen_q | eng_tx_done;
        rx_now = rx_seen_q | eng_rx_valid;
        pick1  = req[1] & (~req[0] | ~last_grant_q);

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d   = pick1 ? 2'b10 : 2'b01;
                    tx_word_d = pick1 ? tx_data1 : tx_data0;
                    freq_d    = pick1 ? freq1 : freq0;
                    loop_d    = pick1 ? loop1 : loop0;
                    settle_d  = 4'd0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (settle_q == SETTLE_LAST) begin
                    start_d = 1'b1;
                    state_d = ST_START;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_START: begin
                state_d = ST_BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ST_BUSY: begin
                tx_seen_d = tx_now;
                rx_seen_d = rx_now;
                if (tx_now && rx_now) begin
                    rx_data_d = eng_rx_data;
                    done_d    = grant_q;
                    state_d   = ST_DONE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    done_d  = grant_q;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                last_grant_d = grant_q[1];
                grant_d      = 2'b00;
                tx_seen_d    = 1'b0;
                rx_seen_d    = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            settle_q     <= 4'd0;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            done_q       <= 2'b00;
            start_q      <= 1'b0;
            rx_data_q    <= 16'h0000;
            tx_seen_q    <= 1'b0;
            rx_seen_q    <= 1'b0;
            tx_word_q    <= 16'h0000;
            freq_q       <= 2'b01;
            loop_q       <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            done_q       <= done_d;
            start_q      <= start_d;
            rx_data_q    <= rx_data_d;
            tx_seen_q    <= tx_seen_d;
            rx_seen_q    <= rx_seen_d;
            tx_word_q    <= tx_word_d;
            freq_q       <= freq_d;
            loop_q       <= loop_d;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q        <= tmo_d;
            err_q        <= err_d;
`endif
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign done             = done_q;
    assign rx_data          = rx_data_q;
    assign grant            = grant_q;
    assign eng_tx_start     = start_q;
    assign eng_rx_start     = start_q;
    assign eng_freq_control = freq_q;
    assign eng_loopback     = loop_q;
    assign eng_tx_data      = tx_word_q;
    assign dbg_state        = state_q;

endmodule

// File: doc/spi_link_arbiter.md
# spi_link_arbiter

Shares the single SPI slave engine (`spi_master_slave_v3_clk_crtl`) between two on-chip requesters: requester 0 is the UART bridge and requester 1 is the multiplier result path. The block arbitrates round-robin and applies the winner's clock-divider select with a settle delay. It then pulses the engine's rx/tx start inputs, waits for transfer completion, and returns the received word and a done/error pulse to the winner. It sits between the requesters and the SPI engine and is the only agent that drives the engine's control inputs.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4: cycles `eng_freq_control` is held stable before the start pulse (1..15).
- `TIMEOUT_CYCLES`, 1023: BUSY-state watchdog limit (used only with `SPI_ARB_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-requester request level; held high until the matching `done` pulse.
- `tx_data0`, `tx_data1`  in  16 each  word to shift out on miso.
- `freq0`, `freq1`  in  2 each  requested `freq_control` code.
- `loop0`, `loop1`  in  1 each  requested loopback mode.
- `done`  out  2  one-cycle completion pulse, one-hot to the granted requester.
- `err`  out  1  valid with `done`; 1 means the transfer timed out.
- `rx_data`  out  16  received word; valid while `done` is nonzero and held until the next capture.
- `grant`  out  2  one-hot owner, nonzero from SETUP through DONE.
- `eng_tx_start`, `eng_rx_start`  out  1 each  one-cycle start pulses to the engine.
- `eng_freq_control`  out  2  engine divider select.
- `eng_loopback`  out  1  engine loopback control.
- `eng_tx_data`  out  16  parallel tx word (engine `miso_reg_data`).
- `eng_rx_data`  in  16  parallel rx word (engine `mosi_reg_data`).
- `eng_tx_done`, `eng_rx_valid`  in  1 each  engine completion flags.

## Operation
- States are IDLE, SETUP, START, BUSY and DONE.
- IDLE: if any `req` bit is set, grant a requester and go to SETUP.
  - With a single request, that requester wins.
  - With both requesting, the winner is the requester not granted last time (`last_grant` resets to 1, so requester 0 wins first).
- Grant latch: on grant, latch the winner's `tx_data`, `freq` and `loop` into `eng_tx_data`, `eng_freq_control` and `eng_loopback`. These stay constant until the next grant; changing requester inputs mid-transfer has no effect.
- SETUP: count `SETTLE_CYCLES`, then go to START.
- START: assert `eng_tx_start` and `eng_rx_start` together for exactly one cycle, then go to BUSY.
- BUSY: use sticky flags `tx_seen` and `rx_seen`.
  - Set a flag on any cycle its engine input is high; the two may arrive in any order or together.
  - When both flags are set, capture `eng_rx_data` into `rx_data`, set `err`=0 and go to DONE.
- DONE: pulse `done[g]` for one cycle, update `last_grant`, clear `grant` and the flags, then return to IDLE.
- Engine completion flags seen outside BUSY are ignored.
- A request dropped before `done` is a protocol violation; the transfer still completes and `done` still pulses.

## Timing
- Reset values: state IDLE; `done`=0, `err`=0, `grant`=0, `rx_data`=0, `eng_*_start`=0, `eng_freq_control`=2'b01, `eng_loopback`=0, `eng_tx_data`=0, `last_grant`=1.
- Request-to-start latency: `req` sampled in cycle N; `grant` is high from N+1; the start pulse comes in cycle N+1+`SETTLE_CYCLES`.
- Completion latency: `done` rises 1 cycle after the cycle in which both flags become set.
- Back-to-back: the next grant is made in the IDLE cycle following DONE, so there is a minimum 1-cycle gap between transactions.
- Reset mid-transfer returns every output to its reset value immediately; the engine is resynchronised by its own reset.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter runs in BUSY.
  - Reaching `TIMEOUT_CYCLES` without both flags set forces DONE with `err`=1 and `rx_data` unchanged.
- Not defined: no counter; BUSY waits indefinitely and `err` is tied to 0.

## Test plan
- Single request: `req`=01, `tx_data0`=16'h55AA, `loop0`=1, `freq0`=01 -> one start pulse in cycle N+5; `done`=01 with `rx_data`=16'h55AA and `err`=0.
- Contention: `req`=11 asserted together, `tx_data0`=16'hA55A, `tx_data1`=16'h1234 -> requester 0 serviced first, then requester 1; `done` order is 01 then 10, with one idle cycle between.
- Fairness: requester 1 holds `req` continuously while requester 0 re-requests immediately -> grants alternate 0,1,0,1 across 4 transactions.
- Skewed completion: `eng_tx_done` arrives 3 cycles before `eng_rx_valid` -> `done` pulses exactly 1 cycle after `eng_rx_valid`.
- Slow clock: `freq1`=11, `tx_data1`=16'h1234 -> `eng_freq_control`=11 is stable for 4 cycles before the start pulse; `rx_data`=16'h1234.
- Timeout and reset (built with the macro, `TIMEOUT_CYCLES`=50):
  - Engine held silent -> `done` with `err`=1 at cycle 51 of BUSY.
  - Separately, `reset` pulsed low during BUSY -> all outputs return to reset values, then a fresh request completes normally.
